cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Sequencing controller for the 2-way set-associative, write-back, write-allocate data cache between the Processor and the RAM.
- Owns the tag, valid, dirty and LRU arrays and the data array.
- Accepts one processor request at a time over a valid/ready handshake.
- Runs lookup, dirty-victim writeback and refill against a variable-latency RAM handshake, then returns a one-cycle response.

Parameters:
- ADDR_WIDTH, 6: byte address width.
- DATA_WIDTH, 8: data word width; one word per line.
- INDEX_WIDTH, 3: set index = ReqAddress[INDEX_WIDTH-1:0]; tag = the remaining upper bits.
- CNT_WIDTH, 8: width of the hit and miss counters.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  reset, asynchronous, active-low.
- ReqValid  in  1  processor request present.
- ReqReady  out  1  controller can accept a request.
- ReqRWB  in  1  1 = write, 0 = read.
- ReqAddress  in  ADDR_WIDTH  request address.
- ReqData  in  DATA_WIDTH  write data.
- RespValid  out  1  one-cycle completion strobe.
- RespData  out  DATA_WIDTH  read data; 0 for writes.
- Hit  out  1  request hit; valid while RespValid is high.
- MemReadEn  out  1  RAM read request, held until MemDone.
- MemWriteEn  out  1  RAM write request, held until MemDone.
- MemAddress  out  ADDR_WIDTH  RAM address.
- MemWriteData  out  DATA_WIDTH  victim data for writeback.
- MemReadData  in  DATA_WIDTH  refill data; valid when MemDone is high.
- MemDone  in  1  RAM completion, sampled only while an enable is high.
- HitCount  out  CNT_WIDTH  saturating hit counter.
- MissCount  out  CNT_WIDTH  saturating miss counter.

Behaviour:
Reset (Reset=0):
- All valid, dirty and LRU bits cleared; state = IDLE.
- Outputs: ReqReady=1 in IDLE; RespValid, Hit, MemReadEn, MemWriteEn = 0; RespData, MemAddress, MemWriteData = 0; counters = 0.
- Reset mid-operation aborts immediately, dropping the Mem enables asynchronously. No array state survives.

States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.

IDLE:
- ReqReady=1; it is 0 in every other state.
- On ReqValid&&ReqReady, register RWB, address and data, then go to LOOKUP.
- ReqValid in non-IDLE states is ignored; the requester holds its request.

LOOKUP (exactly one cycle):
- Hit when a way is valid and its tag matches.
- Hit: increment HitCount, update the way, set LRU = other way, go to RESPOND.
- Miss: increment MissCount and choose the victim.
  - Victim is invalid way0 if any, else invalid way1, else the way named by LRU.
  - If the victim is valid and dirty, go to WRITEBACK.
  - Else a read goes to REFILL and a write installs directly and goes to RESPOND.

WRITEBACK:
- MemWriteEn=1, MemAddress={victimTag,index}, MemWriteData=victim data.
- On MemDone: a read goes to REFILL; a write installs and goes to RESPOND.

REFILL:
- MemReadEn=1, MemAddress=request address.
- On MemDone: install MemReadData with valid=1, dirty=0, then go to RESPOND.

Memory handshake:
- MemDone in the first cycle of a state is honoured, so each state lasts at least 1 cycle.
- Read and write enables are never high together.

Install and update rules:
- Write hit or write install: data=ReqData, valid=1, dirty=1.
- After any access to way w, LRU = ~w.

RESPOND (exactly one cycle):
- RespValid=1.
- RespData = line data for reads, 0 for writes.
- Hit = the registered lookup result.
- Then go to IDLE.

Latency (accept edge to RespValid high):
- Hit: 2 cycles.
- Clean read miss: 3 + RAM cycles.
- Dirty read miss: 4 + the RAM cycles of both transfers.
- Write miss: 2 cycles, plus 1 + RAM cycles if a writeback is needed.

Counters: saturate at 2^CNT_WIDTH-1, with no wrap.

Test Plan:
- Reset release, read 0x0A, MemDone 3 cycles after MemReadEn with MemReadData=0x5C.
  - Expect MemAddress=0x0A, RespValid with RespData=0x5C, Hit=0, MissCount=1.
  - Re-read 0x0A: RespValid 2 cycles after accept, Hit=1, data 0x5C, no Mem enable, HitCount=1.
- Write 0x12←0xA5, then 0x1A←0x3C (set 2 filled, both dirty, no RAM traffic), then read 0x22.
  - Expect MemWriteEn with address 0x12 and data 0xA5, then MemReadEn with address 0x22.
  - Response is Hit=0.
- Read 0x1A after the previous scenario: Hit=1, RespData=0x3C, no RAM traffic (way1 untouched).
- ReqValid held high through a 5-cycle refill: exactly one acceptance; ReqReady=0 from accept until the RespValid cycle ends.
- Reset pulsed low during REFILL: MemReadEn drops without waiting for Clk; after release, a read of the same address misses with MissCount=1.
- 300 consecutive read hits on 0x0A: HitCount=255 with no wrap.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative, write-back, write-allocate cache sequencer with a
// one-word line and a variable-latency RAM handshake.
module cache_controller #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqRWB,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] RespData,
  output logic                  Hit,
  output logic                  MemReadEn,
  output logic                  MemWriteEn,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  input  logic [DATA_WIDTH-1:0] MemReadData,
  input  logic                  MemDone,
  output logic [CNT_WIDTH-1:0]  HitCount,
  output logic [CNT_WIDTH-1:0]  MissCount
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;
  localparam int SETS  = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

  state_t                  state;
  logic                    req_rwb;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    way_q;

  logic [TAG_W-1:0]        tag_q   [2][SETS];
  logic [DATA_WIDTH-1:0]   data_q  [2][SETS];
  logic [SETS-1:0]         valid_q [2];
  logic [SETS-1:0]         dirty_q [2];
  logic [SETS-1:0]         lru_q;

  logic [INDEX_WIDTH-1:0]  idx;
  logic [TAG_W-1:0]        tg;
  logic                    hit0, hit1, victim, victim_dirty;
  logic                    arr_we, arr_way, arr_dirty;
  logic [DATA_WIDTH-1:0]   arr_data;

  assign idx = req_addr[INDEX_WIDTH-1:0];
  assign tg  = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];

  always_comb begin
    hit0 = valid_q[0][idx] && (tag_q[0][idx] == tg);
    hit1 = valid_q[1][idx] && (tag_q[1][idx] == tg);
    if (!valid_q[0][idx])      victim = 1'b0;
    else if (!valid_q[1][idx]) victim = 1'b1;
    else                       victim = lru_q[idx];
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
  end

  // Single line-write port: every hit update and install funnels through here.
  always_comb begin
    arr_we    = 1'b0;
    arr_way   = way_q;
    arr_data  = req_data;
    arr_dirty = 1'b1;
    case (state)
      LOOKUP: begin
        if (hit0 || hit1) begin
          arr_we    = 1'b1;
          arr_way   = hit1;
          arr_data  = req_rwb ? req_data : data_q[hit1][idx];
          arr_dirty = req_rwb | dirty_q[hit1][idx];
        end else if (req_rwb && !victim_dirty) begin
          arr_we  = 1'b1;
          arr_way = victim;
        end
      end
      WRITEBACK: arr_we = MemDone && req_rwb;
      REFILL: begin
        arr_we    = MemDone;
        arr_data  = MemReadData;
        arr_dirty = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      ReqReady     <= 1'b1;
      RespValid    <= 1'b0;
      RespData     <= '0;
      Hit          <= 1'b0;
      MemReadEn    <= 1'b0;
      MemWriteEn   <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      HitCount     <= '0;
      MissCount    <= '0;
      req_rwb      <= 1'b0;
      req_addr     <= '0;
      req_data     <= '0;
      way_q        <= 1'b0;
      lru_q        <= '0;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s]  <= '0;
          data_q[w][s] <= '0;
        end
      end
    end else begin
      if (arr_we) begin
        tag_q[arr_way][idx]   <= tg;
        data_q[arr_way][idx]  <= arr_data;
        valid_q[arr_way][idx] <= 1'b1;
        dirty_q[arr_way][idx] <= arr_dirty;
        lru_q[idx]            <= ~arr_way;
      end
      case (state)
        IDLE: begin
          if (ReqValid && ReqReady) begin
            req_rwb  <= ReqRWB;
            req_addr <= ReqAddress;
            req_data <= ReqData;
            ReqReady <= 1'b0;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit0 || hit1) begin
            if (HitCount != '1) HitCount <= HitCount + CNT_WIDTH'(1);
            Hit       <= 1'b1;
            RespValid <= 1'b1;
            RespData  <= req_rwb ? '0 : data_q[hit1][idx];
            state     <= RESPOND;
          end else begin
            if (MissCount != '1) MissCount <= MissCount + CNT_WIDTH'(1);
            Hit   <= 1'b0;
            way_q <= victim;
            if (victim_dirty) begin
              MemWriteEn   <= 1'b1;
              MemAddress   <= {tag_q[victim][idx], idx};
              MemWriteData <= data_q[victim][idx];
              state        <= WRITEBACK;
            end else if (!req_rwb) begin
              MemReadEn  <= 1'b1;
              MemAddress <= req_addr;
              state      <= REFILL;
            end else begin
              RespValid <= 1'b1;
              RespData  <= '0;
              state     <= RESPOND;
            end
          end
        end
        WRITEBACK: begin
          if (MemDone) begin
            MemWriteEn   <= 1'b0;
            MemWriteData <= '0;
            if (!req_rwb) begin
              MemReadEn  <= 1'b1;
              MemAddress <= req_addr;
              state      <= REFILL;
            end else begin
              MemAddress <= '0;
              RespValid  <= 1'b1;
              RespData   <= '0;
              state      <= RESPOND;
            end
          end
        end
        REFILL: begin
          if (MemDone) begin
            MemReadEn  <= 1'b0;
            MemAddress <= '0;
            RespValid  <= 1'b1;
            RespData   <= MemReadData;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          RespValid <= 1'b0;
          RespData  <= '0;
          Hit       <= 1'b0;
          ReqReady  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against a recency-list cache model
// and a behavioural RAM with programmable completion delay.
module tb_cache_controller;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ReqValid = 1'b0, ReqRWB = 1'b0, MemDone = 1'b0;
  logic [5:0] ReqAddress = '0;
  logic [7:0] ReqData = '0, MemReadData = '0;
  logic       ReqReady, RespValid, Hit, MemReadEn, MemWriteEn;
  logic [7:0] RespData, MemWriteData, HitCount, MissCount;
  logic [5:0] MemAddress;

  always #5 Clk = ~Clk;

  cache_controller #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .INDEX_WIDTH(3), .CNT_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqRWB(ReqRWB),
    .ReqAddress(ReqAddress), .ReqData(ReqData), .RespValid(RespValid), .RespData(RespData),
    .Hit(Hit), .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData), .MemDone(MemDone),
    .HitCount(HitCount), .MissCount(MissCount)
  );

  int total = 0, bad = 0;
  int acc_cnt = 0, n_req = 0;
  bit both_en = 1'b0;

  // RAM image and cache model: each set is a list of lines, most recent first.
  logic [7:0] ram [64];
  int         m_n [8];
  logic [2:0] m_tag [8][2];
  logic [7:0] m_dat [8][2];
  bit         m_dirty [8][2];
  int         m_hc, m_mc;

  bit         e_hit, e_wb, e_rf;
  logic [5:0] e_wb_addr, e_rf_addr;
  logic [7:0] e_wb_data, e_data;

  logic [7:0] o_data, o_wb_data;
  logic [5:0] o_wb_addr, o_rf_addr;
  bit         o_hit;
  int         o_lat, o_hc, o_mc;

  always @(posedge Clk) if (Reset && ReqValid && ReqReady) acc_cnt <= acc_cnt + 1;
  always @(negedge Clk) if (MemReadEn && MemWriteEn) both_en <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) m_n[s] = 0;
    m_hc = 0;
    m_mc = 0;
  endtask

  task automatic model_access(input bit rw, input logic [5:0] a, input logic [7:0] d);
    int i, p;
    logic [2:0] t;
    logic [7:0] dd;
    bit dr;
    i = int'(a[2:0]);
    t = a[5:3];
    p = -1;
    e_wb = 1'b0;
    e_rf = 1'b0;
    for (int k = 0; k < m_n[i]; k++) if (m_tag[i][k] == t) p = k;
    if (p >= 0) begin
      e_hit = 1'b1;
      if (m_hc < 255) m_hc++;
      dd = rw ? d : m_dat[i][p];
      dr = rw | m_dirty[i][p];
      e_data = rw ? 8'h00 : dd;
      for (int k = p; k > 0; k--) begin
        m_tag[i][k] = m_tag[i][k-1]; m_dat[i][k] = m_dat[i][k-1]; m_dirty[i][k] = m_dirty[i][k-1];
      end
      m_tag[i][0] = t; m_dat[i][0] = dd; m_dirty[i][0] = dr;
    end else begin
      e_hit = 1'b0;
      if (m_mc < 255) m_mc++;
      if (m_n[i] == 2) begin
        if (m_dirty[i][1]) begin
          e_wb      = 1'b1;
          e_wb_addr = {m_tag[i][1], a[2:0]};
          e_wb_data = m_dat[i][1];
          ram[e_wb_addr] = e_wb_data;
        end
        m_n[i] = 1;
      end
      if (m_n[i] == 1) begin
        m_tag[i][1] = m_tag[i][0]; m_dat[i][1] = m_dat[i][0]; m_dirty[i][1] = m_dirty[i][0];
      end
      m_n[i]++;
      m_tag[i][0] = t;
      if (rw) begin
        m_dat[i][0] = d; m_dirty[i][0] = 1'b1; e_data = 8'h00;
      end else begin
        e_rf = 1'b1; e_rf_addr = a;
        m_dat[i][0] = ram[a]; m_dirty[i][0] = 1'b0; e_data = ram[a];
      end
    end
  endtask

  // One transaction: drive, play the RAM, compare every observable against the model.
  task automatic do_req(input bit rw, input logic [5:0] a, input logic [7:0] d,
                        input int l1, input int l2, input bit hold);
    int lat_exp, cyc, w;
    logic [1:0] en, prev;
    bit done, rr_bad, seen_wb, seen_rf;
    @(negedge Clk);
    chk("ready_idle", 32'(ReqReady), 32'd1);
    model_access(rw, a, d);
    lat_exp = e_hit ? 2 : 2 + (e_wb ? 1 + l1 : 0) + (e_rf ? 1 + l2 : 0);
    ReqValid = 1'b1; ReqRWB = rw; ReqAddress = a; ReqData = d;
    n_req++;
    cyc = 0; w = 0; prev = 2'b00;
    done = 1'b0; rr_bad = 1'b0; seen_wb = 1'b0; seen_rf = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge Clk);
      cyc++;
      if (!hold) ReqValid = 1'b0;
      MemDone = 1'b0;
      if (ReqReady) rr_bad = 1'b1;
      en = {MemWriteEn, MemReadEn};
      if (en != prev) w = 0;
      if (MemWriteEn && !prev[1]) begin
        seen_wb = 1'b1; o_wb_addr = MemAddress; o_wb_data = MemWriteData;
      end
      if (MemReadEn && !prev[0]) begin
        seen_rf = 1'b1; o_rf_addr = MemAddress;
      end
      if (en != 2'b00) begin
        if (w == (MemWriteEn ? l1 : l2)) begin
          MemDone = 1'b1;
          MemReadData = ram[MemAddress];
        end
        w++;
      end
      prev = en;
      if (RespValid) begin
        done = 1'b1; ReqValid = 1'b0;
        o_data = RespData; o_hit = Hit; o_lat = cyc; o_hc = int'(HitCount); o_mc = int'(MissCount);
      end
    end
    chk("resp_seen", 32'(done), 32'd1);
    chk("latency", 32'(cyc), 32'(lat_exp));
    chk("hit", 32'(o_hit), 32'(e_hit));
    chk("resp_data", 32'(o_data), 32'(e_data));
    chk("hit_count", 32'(o_hc), 32'(m_hc));
    chk("miss_count", 32'(o_mc), 32'(m_mc));
    chk("ready_low_busy", 32'(rr_bad), 32'd0);
    chk("wb_issued", 32'(seen_wb), 32'(e_wb));
    chk("rf_issued", 32'(seen_rf), 32'(e_rf));
    if (e_wb && seen_wb) begin
      chk("wb_addr", 32'(o_wb_addr), 32'(e_wb_addr));
      chk("wb_data", 32'(o_wb_data), 32'(e_wb_data));
    end
    if (e_rf && seen_rf) chk("rf_addr", 32'(o_rf_addr), 32'(e_rf_addr));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
    ram[6'h0A] = 8'h5C;
    model_clear();
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(ReqReady), 32'd1);
    chk("rst_strobes", 32'({RespValid, Hit, MemReadEn, MemWriteEn}), 32'd0);
    chk("rst_buses", 32'({RespData, MemAddress, MemWriteData}), 32'd0);
    chk("rst_counts", 32'({HitCount, MissCount}), 32'd0);

    // cold read miss, then re-read hit
    do_req(1'b0, 6'h0A, 8'h00, 0, 3, 1'b0);
    chk("s1_rf_addr", 32'(o_rf_addr), 32'h0A);
    chk("s1_data", 32'(o_data), 32'h5C);
    chk("s1_hit", 32'(o_hit), 32'd0);
    chk("s1_miss", 32'(o_mc), 32'd1);
    do_req(1'b0, 6'h0A, 8'h00, 0, 0, 1'b0);
    chk("s2_lat", 32'(o_lat), 32'd2);
    chk("s2_hit", 32'(o_hit), 32'd1);
    chk("s2_data", 32'(o_data), 32'h5C);
    chk("s2_hits", 32'(o_hc), 32'd1);

    // dirty eviction in set 2
    do_req(1'b1, 6'h12, 8'hA5, 0, 0, 1'b0);
    do_req(1'b1, 6'h1A, 8'h3C, 0, 0, 1'b0);
    do_req(1'b0, 6'h22, 8'h00, 2, 2, 1'b0);
    chk("s3_wb_addr", 32'(o_wb_addr), 32'h12);
    chk("s3_wb_data", 32'(o_wb_data), 32'hA5);
    chk("s3_rf_addr", 32'(o_rf_addr), 32'h22);
    chk("s3_hit", 32'(o_hit), 32'd0);
    do_req(1'b0, 6'h1A, 8'h00, 0, 0, 1'b0);
    chk("s4_hit", 32'(o_hit), 32'd1);
    chk("s4_data", 32'(o_data), 32'h3C);

    // request held high across a 5-cycle refill
    do_req(1'b0, 6'h3F, 8'h00, 0, 5, 1'b1);
    chk("s5_lat", 32'(o_lat), 32'd8);

    for (int n = 0; n < 150; n++)
      do_req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

    // reset while a refill is outstanding
    @(negedge Clk) Reset = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    model_clear();
    @(negedge Clk);
    ReqValid = 1'b1; ReqRWB = 1'b0; ReqAddress = 6'h2D;
    n_req++;
    @(negedge Clk) ReqValid = 1'b0;
    k = 0;
    while (!MemReadEn && k < 10) begin
      @(negedge Clk);
      k++;
    end
    chk("s6_refill_busy", 32'(MemReadEn), 32'd1);
    #2 Reset = 1'b0;
    #1 chk("s6_async_drop", 32'(MemReadEn), 32'd0);
    @(negedge Clk) Reset = 1'b1;
    model_clear();
    do_req(1'b0, 6'h2D, 8'h00, 0, 2, 1'b0);
    chk("s6_hit", 32'(o_hit), 32'd0);
    chk("s6_miss", 32'(o_mc), 32'd1);

    // hit counter saturation
    do_req(1'b0, 6'h0A, 8'h00, 0, 1, 1'b0);
    for (int n = 0; n < 300; n++) do_req(1'b0, 6'h0A, 8'h00, 0, 0, 1'($urandom_range(0, 1)));
    chk("s7_hits_sat", 32'(o_hc), 32'd255);
    chk("s7_misses", 32'(o_mc), 32'd2);

    @(negedge Clk);
    chk("accept_count", 32'(acc_cnt), 32'(n_req));
    chk("enables_exclusive", 32'(both_en), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
